vector_elem_seq: RTL

Element sequencer that consumes the vector CSR state (vl, vsew, vta, vill) and walks one vector instruction's body elements in order. For each element it issues the element index and byte offset into the VLEN-wide register file, with a valid/ready handshake toward the lane datapath. It sits between instruction issue (which pulses start after vsetvl state is settled) and the lane/regfile access logic, and reports completion back to issue.

---
 rtl/vpu_pkg.sv | 27 ++
 rtl/vector_vl_clamp.sv | 20 ++
 rtl/vector_elem_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vpu_pkg.sv
// Shared vector-unit definitions: SEW encodings, ELEN, VLMAX helper and sequencer state codes.
package vpu_pkg;

    localparam int unsigned ELEN = 32;

    localparam logic [2:0] SEW_E8  = 3'd0;
    localparam logic [2:0] SEW_E16 = 3'd1;
    localparam logic [2:0] SEW_E32 = 3'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Encodings 3..7 are reserved.
    function automatic logic sew_reserved(input logic [2:0] sew);
        return sew > SEW_E32;
    endfunction

    function automatic int unsigned vlmax(input int unsigned vlen, input logic [2:0] sew);
        case (sew)
            SEW_E8:  return vlen / 8;
            SEW_E16: return vlen / 16;
            default: return vlen / ELEN;
        endcase
    endfunction

endpackage

// File: rtl/vector_vl_clamp.sv
// Combinational VLMAX lookup and clamp of the CSR vl to VLMAX for the selected SEW.
module vector_vl_clamp
    import vpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned VLEN  = 256,
    parameter int unsigned CNT_W = $clog2(VLEN / 8) + 1
) (
    input  logic [WIDTH-1:0] vl_i,
    input  logic [2:0]       vsew_i,
    output logic [CNT_W-1:0] vlmax_o,
    output logic [CNT_W-1:0] eff_vl_o
);

    always_comb begin
        vlmax_o  = CNT_W'(vlmax(VLEN, vsew_i));
        eff_vl_o = (vl_i > WIDTH'(vlmax_o)) ? vlmax_o : CNT_W'(vl_i);
    end

endmodule

// File: rtl/vector_elem_seq.sv
// Walks the body elements of one vector instruction, issuing index/byte offset per element.
// Optional tail walk (vta=1 walks up to VLMAX-1) is enabled by defining VPU_TAIL_WALK_EN.
module vector_elem_seq
    import vpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned VLEN  = 256
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [WIDTH-1:0]              i_vl,
    input  logic [2:0]                    i_vsew,
    input  logic                          i_vta,
    input  logic                          i_vill,
    input  logic                          i_elem_ready,
    output logic                          o_busy,
    output logic                          o_elem_valid,
    output logic [$clog2(VLEN/8)-1:0]     o_elem_idx,
    output logic [$clog2(VLEN/8)-1:0]     o_byte_off,
    output logic                          o_elem_tail,
    output logic                          o_done,
    output logic                          o_illegal
);

    localparam int unsigned IDX_W = $clog2(VLEN / 8);
    // One extra bit so a full count (VLMAX at e8) does not wrap.
    localparam int unsigned CNT_W = IDX_W + 1;

`ifdef VPU_TAIL_WALK_EN
    localparam logic TAIL_WALK = 1'b1;
`else
    localparam logic TAIL_WALK = 1'b0;
`endif

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] off_q, off_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] vl_q, vl_d;
    logic [1:0]       sew_q, sew_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             tail_q, tail_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;

    logic [CNT_W-1:0] vlmax_c;
    logic [CNT_W-1:0] eff_vl_c;
    logic [CNT_W-1:0] walk_len_c;
    logic [CNT_W-1:0] idx_inc_c;
    logic [IDX_W-1:0] idx_nxt_c;

    vector_vl_clamp #(
        .WIDTH (WIDTH),
        .VLEN  (VLEN),
        .CNT_W (CNT_W)
    ) u_vl_clamp (
        .vl_i     (i_vl),
        .vsew_i   (i_vsew),
        .vlmax_o  (vlmax_c),
        .eff_vl_o (eff_vl_c)
    );

    assign walk_len_c = (TAIL_WALK && i_vta) ? vlmax_c : eff_vl_c;
    assign idx_inc_c  = CNT_W'(idx_q) + CNT_W'(1);
    assign idx_nxt_c  = idx_inc_c[IDX_W-1:0];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        off_d     = off_q;
        len_d     = len_q;
        vl_d      = vl_q;
        sew_d     = sew_q;
        busy_d    = 1'b0;
        valid_d   = 1'b0;
        tail_d    = tail_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idx_d  = '0;
                off_d  = '0;
                tail_d = 1'b0;
                if (i_start) begin
                    if (i_vill || sew_reserved(i_vsew)) begin
                        illegal_d = 1'b1;
                    end else begin
                        sew_d  = i_vsew[1:0];
                        vl_d   = eff_vl_c;
                        len_d  = walk_len_c;
                        busy_d = 1'b1;
                        if (walk_len_c == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                            valid_d = 1'b1;
                            tail_d  = TAIL_WALK && (eff_vl_c == '0);
                        end
                    end
                end
            end

            // Descriptor holds until the lane accepts it.
            ST_RUN: begin
                busy_d  = 1'b1;
                valid_d = 1'b1;
                if (valid_q && i_elem_ready) begin
                    if (idx_inc_c == len_q) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        off_d   = '0;
                        tail_d  = 1'b0;
                    end else begin
                        idx_d  = idx_nxt_c;
                        off_d  = idx_nxt_c << sew_q;
                        tail_d = TAIL_WALK && (idx_inc_c >= vl_q);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            off_q     <= '0;
            len_q     <= '0;
            vl_q      <= '0;
            sew_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            tail_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            off_q     <= off_d;
            len_q     <= len_d;
            vl_q      <= vl_d;
            sew_q     <= sew_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            tail_q    <= tail_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign o_busy       = busy_q;
    assign o_elem_valid = valid_q;
    assign o_elem_idx   = idx_q;
    assign o_byte_off   = off_q;
    assign o_elem_tail  = tail_q;
    assign o_done       = done_q;
    assign o_illegal    = illegal_q;

endmodule
